// File: rtl/bus_conflict_table_nway_if.sv
// Bus bundle for the N-way conflict table: lookup, increment and decrement
// channels plus status outputs.
interface bus_conflict_table_nway_if #(
    parameter int BLOCK_ADDR_WIDTH = 29,
    parameter int MAX_OUTSTANDING  = 8
);
    localparam int OUT_WIDTH = $clog2(MAX_OUTSTANDING + 1);

    logic                        chk_valid;
    logic [BLOCK_ADDR_WIDTH-1:0] chk_addr;
    logic                        chk_resp_valid;
    logic                        chk_conflict;
    logic                        inc_valid;
    logic [BLOCK_ADDR_WIDTH-1:0] inc_addr;
    logic                        inc_ready;
    logic                        dec_valid;
    logic [BLOCK_ADDR_WIDTH-1:0] dec_addr;
    logic [OUT_WIDTH-1:0]        outstanding;
    logic                        underflow_err;

    modport master (
        output chk_valid, chk_addr, inc_valid, inc_addr, dec_valid, dec_addr,
        input  chk_resp_valid, chk_conflict, inc_ready, outstanding, underflow_err
    );

    modport slave (
        input  chk_valid, chk_addr, inc_valid, inc_addr, dec_valid, dec_addr,
        output chk_resp_valid, chk_conflict, inc_ready, outstanding, underflow_err
    );
endinterface

// File: rtl/bus_conflict_table_nway.sv
// N-way skewed counting conflict table: per-way saturating counters tracking
// in-flight dbus transactions, with a 1-cycle pipelined conflict lookup.
module bus_conflict_table_nway #(
    parameter int BLOCK_ADDR_WIDTH = 29,
    parameter int NUM_SETS         = 8,
    parameter int NUM_WAYS         = 2,
    parameter int COUNT_WIDTH      = 2,
    parameter int MAX_OUTSTANDING  = 8
) (
    input  logic                      CLK,
    input  logic                      RST,
    bus_conflict_table_nway_if.slave  bus
);
    localparam int unsigned IDX = $clog2(NUM_SETS);
    localparam int          OW  = $clog2(MAX_OUTSTANDING + 1);
    localparam logic [OW-1:0] OUT_MAX = OW'(MAX_OUTSTANDING);

    logic [COUNT_WIDTH-1:0] cnt [NUM_WAYS][NUM_SETS];

    logic [NUM_WAYS-1:0] chk_nz;
    logic [NUM_WAYS-1:0] inc_sat;
    logic [NUM_WAYS-1:0] dec_nz;

    logic          inc_acc;
    logic          dec_acc;
    logic          dec_bad;
    logic          chk_resp_q;
    logic          chk_conflict_q;
    logic [OW-1:0] outstanding_q;
    logic          underflow_q;

    // Way 0 uses the low index bits directly; way w XORs them with the w-th
    // index-wide slice so aliases in one way rarely alias in the others.
    function automatic logic [IDX-1:0] idx_of(input logic [BLOCK_ADDR_WIDTH-1:0] a,
                                              input int unsigned w);
        logic [BLOCK_ADDR_WIDTH-1:0] sh;
        sh = a >> (w * IDX);
        idx_of = (w == 0) ? a[IDX-1:0] : (a[IDX-1:0] ^ sh[IDX-1:0]);
    endfunction

    for (genvar w = 0; w < NUM_WAYS; w++) begin : g_way
        logic [IDX-1:0] ci;
        logic [IDX-1:0] ii;
        logic [IDX-1:0] di;

        assign ci = idx_of(bus.chk_addr, w);
        assign ii = idx_of(bus.inc_addr, w);
        assign di = idx_of(bus.dec_addr, w);

        assign chk_nz[w]  = (cnt[w][ci] != '0);
        assign inc_sat[w] = (cnt[w][ii] == '1);
        assign dec_nz[w]  = (cnt[w][di] != '0);

        for (genvar s = 0; s < NUM_SETS; s++) begin : g_set
            logic                   up;
            logic                   dn;
            logic [COUNT_WIDTH-1:0] c;

            assign up = inc_acc && (ii == IDX'(s));
            assign dn = dec_acc && (di == IDX'(s));
            assign cnt[w][s] = c;

            // Inc and dec landing on the same counter cancel out.
            always_ff @(posedge CLK or posedge RST) begin
                if (RST) begin
                    c <= '0;
                end else if (up && !dn) begin
                    c <= c + 1'b1;
                end else if (dn && !up) begin
                    c <= c - 1'b1;
                end
            end
        end
    end

    assign bus.inc_ready = (outstanding_q != OUT_MAX) && !(|inc_sat);
    assign inc_acc       = bus.inc_valid && bus.inc_ready;
    assign dec_acc       = bus.dec_valid && (&dec_nz);
    assign dec_bad       = bus.dec_valid && !(&dec_nz);

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            chk_resp_q     <= 1'b0;
            chk_conflict_q <= 1'b0;
            outstanding_q  <= '0;
            underflow_q    <= 1'b0;
        end else begin
            chk_resp_q <= bus.chk_valid;
            if (bus.chk_valid) begin
                chk_conflict_q <= &chk_nz;
            end
            if (inc_acc && !dec_acc) begin
                outstanding_q <= outstanding_q + 1'b1;
            end else if (dec_acc && !inc_acc) begin
                outstanding_q <= outstanding_q - 1'b1;
            end
            if (dec_bad) begin
                underflow_q <= 1'b1;
            end
        end
    end

    assign bus.chk_resp_valid = chk_resp_q;
    assign bus.chk_conflict   = chk_conflict_q;
    assign bus.outstanding    = outstanding_q;
    assign bus.underflow_err  = underflow_q;
endmodule
